frame_stream_sink: RTL and testbench
====================================

// Module: frame_stream_sink
// PURPOSE
//  Receiving end of the SRAM transform adapter's pixel stream: captures the unthrottled one-pixel-per-cycle
//  output (pixel, line-start marker, done), checks frame geometry, and re-times it through a FIFO onto a
//  valid/ready stream with SOF/EOL tags for downstream consumers (display/DMA writer).
// PARAMETERS
//  IMG_W      1024  pixels per row
//  IMG_H      1024  rows per frame
//  DATA_W     24    pixel width (RGB888)
//  FIFO_AW    4     FIFO address bits; depth = 2**FIFO_AW entries of DATA_W+2 bits {sof,eol,pixel}
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: arm capture of one frame (ignored unless IDLE)
//  pix_in       in   DATA_W  pixel from adapter, sampled every cycle while armed
//  jump_in      in   1       high on the first pixel of each row
//  done_in      in   1       adapter end-of-frame indication
//  m_data       out  DATA_W  output pixel
//  m_sof        out  1       m_data is pixel (0,0)
//  m_eol        out  1       m_data is last pixel of a row
//  m_valid      out  1       output beat valid
//  m_ready      in   1       downstream accept; beat transfers when m_valid&&m_ready
//  busy         out  1       high in WAIT_SOF/CAPTURE/DRAIN
//  frame_done   out  1       1-cycle pulse when frame fully drained
//  overflow     out  1       sticky: a pixel was dropped on FIFO full
//  len_err      out  1       sticky: geometry mismatch seen
//  checksum     out  32      see CONFIGURATION
// BEHAVIOUR
//  - Reset: FSM=IDLE, col=row=0, FIFO emptied; m_valid, busy, frame_done, overflow, len_err, checksum = 0.
//    Reset mid-frame discards all captured/buffered pixels; no frame_done.
//  - FSM IDLE -> WAIT_SOF on start (clears overflow, len_err, checksum). Inputs ignored in IDLE.
//  - WAIT_SOF: pixels ignored until jump_in=1; that pixel is (0,0), pushed with sof=1, -> CAPTURE.
//  - CAPTURE: one push per cycle; col 0..IMG_W-1, wraps to 0 with row+1. eol=1 when col==IMG_W-1.
//    jump_in must equal (col==0); any mismatch sets len_err, counters keep free-running (no resync).
//    After pushing (IMG_W-1,IMG_H-1) -> DRAIN. done_in before that pixel: set len_err, stop pushing,
//    -> DRAIN. done_in on/after last pixel: no error.
//  - DRAIN: no pushes; when FIFO empty and no beat pending -> frame_done=1 for one cycle, -> IDLE.
//  - FIFO: registered output, m_valid = !empty; first pixel visible on m_data 1 cycle after push.
//    Push on full with simultaneous pop: accepted, no loss. Push on full without pop: pixel dropped,
//    overflow set, counters still advance (geometry tags stay correct for surviving pixels).
//    m_data/m_sof/m_eol stable while m_valid&&!m_ready.
//  - Counters width: $clog2(IMG_W), $clog2(IMG_H); comparisons against IMG_W-1/IMG_H-1, no wrap past frame.
//  - start while busy: ignored, no flag change.
// CONFIGURATION
//  FRAME_SINK_CHECKSUM_EN defined: checksum = sum mod 2^32 of every pushed pixel (zero-extended, dropped
//    pixels excluded), cleared on start, final value valid from frame_done cycle until next start.
//  Not defined: no adder logic; checksum tied to 32'd0. Port list identical both ways.
// TESTING  (IMG_W=4, IMG_H=4, FIFO_AW=2 unless noted)
//  1 start, 16-cycle stream with jump_in every 4th pixel, pixel=index, m_ready=1 -> 16 beats 0..15 in order,
//    m_sof on beat 0 only, m_eol on beats 3,7,11,15, frame_done 1 cycle after last beat, flags 0.
//  2 jump_in held 0 for 5 cycles after start, then normal frame -> first 5 pixels discarded, beat 0 = pixel
//    sampled with first jump_in.
//  3 m_ready=0 throughout -> first 4 pixels kept, remaining 12 dropped, overflow=1; then m_ready=1 ->
//    4 beats out, frame_done pulses, no hang.
//  4 jump_in asserted at col 2 of row 1 -> len_err=1; done_in at pixel 9 -> len_err stays 1, 10 beats,
//    frame_done pulses.
//  5 rst asserted at pixel 6 with FIFO non-empty -> next cycle m_valid=0, busy=0, flags 0; new start runs
//    test 1 cleanly.
//  6 FRAME_SINK_CHECKSUM_EN, pixels 0..15 -> checksum=120 at frame_done; without macro -> 0.

Source files
------------

// File: rtl/frame_stream_sink.sv
// Pixel stream sink: captures the adapter's one-pixel-per-cycle output, checks frame geometry and re-times it
// through a FIFO onto a valid/ready stream with SOF/EOL tags. Optional checksum via FRAME_SINK_CHECKSUM_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | inputs ignored, waiting for start
// WAIT_SOF | armed, discarding pixels until the first jump_in marks (0,0)
// CAPTURE  | pushing one pixel per cycle, tracking col/row and geometry
// DRAIN    | capture finished, emptying the FIFO before frame_done
module frame_stream_sink #(
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 1024,
  parameter int DATA_W  = 24,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              jump_in,
  input  logic              done_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              len_err,
  output logic [31:0]       checksum
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]      ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;

  logic [DATA_W+1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                push_sof;
  logic                pop;
  logic                accept;
  logic                drop;
  logic                col_last;
  logic                at_last;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign col_last   = (col == COL_LAST);
  assign at_last    = col_last && (row == ROW_LAST);

  assign push_sof = (state == S_WAIT_SOF);
  assign push     = (state == S_CAPTURE) || ((state == S_WAIT_SOF) && jump_in);
  assign pop      = !fifo_empty && m_ready;
  // A full FIFO still takes a pixel when a beat leaves in the same cycle.
  assign accept   = push && (!fifo_full || pop);
  assign drop     = push && fifo_full && !pop;

  assign m_valid = !fifo_empty;
  assign {m_sof, m_eol, m_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {push_sof, col_last, pix_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
      end

      // Counters advance on every capture cycle, dropped or not, and hold at the final pixel.
      if (push && !at_last) begin
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WAIT_SOF;
            busy     <= 1'b1;
            overflow <= 1'b0;
            len_err  <= 1'b0;
            col      <= '0;
            row      <= '0;
          end
        end

        S_WAIT_SOF: begin
          if (jump_in) begin
            if (at_last) begin
              state <= S_DRAIN;
            end else if (done_in) begin
              len_err <= 1'b1;
              state   <= S_DRAIN;
            end else begin
              state <= S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (jump_in != (col == '0)) begin
            len_err <= 1'b1;
          end
          if (at_last) begin
            state <= S_DRAIN;
          end else if (done_in) begin
            len_err <= 1'b1;
            state   <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Finish on the cycle the last beat leaves so frame_done follows it directly.
          if (fifo_empty || ((count == CNT_ONE) && pop)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SINK_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + 32'(pix_in);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_frame_stream_sink.sv
// Directed bench for frame_stream_sink at IMG_W=IMG_H=4, FIFO_AW=2: frame scenarios from a vector table,
// a beat monitor checking order/tags/frame_done timing, and a mid-frame reset sequence.
module tb_frame_stream_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] pix_in;
  logic        jump_in;
  logic        done_in;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic        len_err;
  logic [31:0] checksum;

  frame_stream_sink #(
    .IMG_W  (4),
    .IMG_H  (4),
    .DATA_W (24),
    .FIFO_AW(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_in    (pix_in),
    .jump_in   (jump_in),
    .done_in   (done_in),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .overflow  (overflow),
    .len_err   (len_err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre;        // junk cycles before the first jump_in
    int bad;        // extra jump_in at this pixel index (-1 none)
    int done_i;     // done_in with this pixel index (-1 none)
    int restart;    // start pulse with this pixel index (-1 none)
    bit rdy;        // m_ready level while streaming
    int exp_beats;
    int exp_last;
    bit exp_ovf;
    bit exp_len;
    int exp_cks;    // checksum when enabled
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          beat_idx = 0;
  int          fd_cnt   = 0;
  int          last_beat_cyc = 0;
  logic [31:0] last_data = '0;
  vec_t        vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        check("beat_data", 32'(m_data), 32'(beat_idx));
        check("beat_sof", 32'(m_sof), 32'(beat_idx == 0));
        check("beat_eol", 32'(m_eol), 32'(beat_idx % 4 == 3));
        last_data     = 32'(m_data);
        last_beat_cyc = cyc;
        beat_idx++;
      end
      if (frame_done) begin
        fd_cnt++;
        check("fd_latency", 32'(cyc - last_beat_cyc), 32'd1);
        check("fd_valid_low", 32'(m_valid), 32'd0);
      end
    end
  end

  function automatic int cks_exp(input int v);
`ifdef FRAME_SINK_CHECKSUM_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic run_frame(input vec_t v);
    int fd0;
    int waited;
    fd0 = fd_cnt;
    @(posedge clk); #1;
    m_ready  = v.rdy;
    start    = 1'b1;
    beat_idx = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < v.pre; k++) begin
      pix_in  = 24'(100 + k);
      jump_in = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) begin
      pix_in  = 24'(i);
      jump_in = (i % 4 == 0) || (i == v.bad);
      done_in = (i == v.done_i);
      start   = (i == v.restart);
      @(posedge clk); #1;
      if (i == v.done_i) break;
    end
    pix_in  = '0;
    jump_in = 1'b0;
    done_in = 1'b0;
    start   = 1'b0;
    m_ready = 1'b1;
    waited  = 0;
    while (fd_cnt == fd0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("fd_within_bound", 32'(waited < 200), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("fd_pulses", 32'(fd_cnt - fd0), 32'd1);
    check("beats", 32'(beat_idx), 32'(v.exp_beats));
    check("last_beat", last_data, 32'(v.exp_last));
    check("overflow", 32'(overflow), 32'(v.exp_ovf));
    check("len_err", 32'(len_err), 32'(v.exp_len));
    check("checksum", checksum, 32'(cks_exp(v.exp_cks)));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int fd0;
    //            pre bad done rst rdy beats last ovf len  cks
    vecs[0] = '{0, -1, -1, -1, 1'b1, 16, 15, 1'b0, 1'b0, 120};  // clean frame
    vecs[1] = '{5, -1, -1,  8, 1'b1, 16, 15, 1'b0, 1'b0, 120};  // late SOF, start while busy
    vecs[2] = '{0, -1, -1, -1, 1'b0,  4,  3, 1'b1, 1'b0,   6};  // stalled: overflow
    vecs[3] = '{0,  6,  9, -1, 1'b1, 10,  9, 1'b0, 1'b1,  45};  // bad jump, early done
    vecs[4] = '{0, -1, 15, -1, 1'b1, 16, 15, 1'b0, 1'b0, 120};  // done on last pixel

    rst = 1'b1; start = 1'b0; pix_in = '0; jump_in = 1'b0; done_in = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ignores_input", 32'(m_valid), 32'd0);

    for (int t = 0; t < 5; t++) begin
      run_frame(vecs[t]);
    end

    // Mid-frame reset with a non-empty FIFO, then a clean frame.
    fd0 = fd_cnt;
    @(posedge clk); #1;
    m_ready = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pix_in  = 24'(i);
      jump_in = (i % 4 == 0);
      @(posedge clk); #1;
    end
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    pix_in  = 24'd6;
    jump_in = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_len_err", 32'(len_err), 32'd0);
    check("mid_rst_checksum", checksum, 32'd0);
    rst     = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_fd", 32'(fd_cnt - fd0), 32'd0);
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
